// File: rtl/id_queue_decoder_pkg.sv
// Shared MIPS32 decode constants for the HeliumCPUv2 decode stage: opcodes,
// funct codes, instruction-type codes and opcode-class helpers.
package id_queue_decoder_pkg;

    typedef enum logic [1:0] {
        R_TYPE = 2'd0,
        I_TYPE = 2'd1,
        J_TYPE = 2'd2
    } inst_type_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f, OP_LB     = 6'h20, OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08;

    function automatic logic is_load_op(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // ALU-immediate ops whose immediate is sign-extended
    function automatic logic is_arith_imm_op(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU};
    endfunction

    function automatic logic is_logic_imm_op(input logic [5:0] op);
        return op inside {OP_ANDI, OP_ORI, OP_XORI};
    endfunction

    function automatic logic is_branch_op(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM};
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational MIPS32 field decoder: raw fields, type, extended immediate,
// write destination and the register-read flags used for load-use detection.
module inst_field_decode
    import id_queue_decoder_pkg::*;
#(
    parameter int W          = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [W-1:0]          inst,
    input  logic [W-1:0]          pc,
    output logic [5:0]            op_code,
    output logic [5:0]            funct,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [4:0]            shamt,
    output logic [1:0]            inst_type,
    output logic [W-1:0]          imm,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic                  is_load,
    output logic                  reads_rs,
    output logic                  reads_rt
);

    logic [W-1:0] pc_plus4;
    logic         unused_pc_low;

    assign pc_plus4      = pc + W'(4);
    assign unused_pc_low = ^pc_plus4[W-5:0];

    // NOTE: every output is given a default first so no path through this block infers a latch.
    always_comb begin
        op_code        = inst[31:26];
        funct          = inst[5:0];
        rs             = REG_ADDR_W'(inst[25:21]);
        rt             = REG_ADDR_W'(inst[20:16]);
        rd             = REG_ADDR_W'(inst[15:11]);
        shamt          = inst[10:6];
        inst_type      = I_TYPE;
        imm            = '0;
        reg_write_addr = '0;
        is_load        = is_load_op(op_code);
        reads_rs       = !(op_code inside {OP_J, OP_JAL, OP_LUI});
        reads_rt       = (op_code == OP_SPECIAL) || is_store_op(op_code) ||
                         (op_code inside {OP_BEQ, OP_BNE});

        if (op_code == OP_SPECIAL) begin
            inst_type      = R_TYPE;
            imm            = (funct inside {FN_SLL, FN_SRL, FN_SRA}) ? W'(shamt) : '0;
            reg_write_addr = (funct == FN_JR) ? '0 : rd;
        end else if (op_code inside {OP_J, OP_JAL}) begin
            inst_type      = J_TYPE;
            imm            = W'({pc_plus4[W-1:W-4], inst[25:0], 2'b00});
            reg_write_addr = (op_code == OP_JAL) ? REG_ADDR_W'(31) : '0;
        end else if (is_load_op(op_code) || is_arith_imm_op(op_code)) begin
            imm            = {{(W-16){inst[15]}}, inst[15:0]};
            reg_write_addr = rt;
        end else if (is_store_op(op_code)) begin
            imm            = {{(W-16){inst[15]}}, inst[15:0]};
        end else if (is_logic_imm_op(op_code)) begin
            imm            = W'(inst[15:0]);
            reg_write_addr = rt;
        end else if (op_code == OP_LUI) begin
            imm            = W'({inst[15:0], 16'h0000});
            reg_write_addr = rt;
        end else if (is_branch_op(op_code)) begin
            imm            = {{(W-18){inst[15]}}, inst[15:0], 2'b00};
        end
    end

endmodule

// File: rtl/id_queue_decoder.sv
// Two-entry (output + skid) decode stage with valid/ready on both sides and
// hardware load-use bubble insertion.
module id_queue_decoder
    import id_queue_decoder_pkg::*;
#(
    parameter int W          = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LU_DETECT  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          inst,
    input  logic [W-1:0]          pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            op_code,
    output logic [5:0]            funct,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [4:0]            shamt,
    output logic [1:0]            inst_type,
    output logic [W-1:0]          imm,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic [W-1:0]          pc_out,
    output logic [CNT_W-1:0]      lu_bubbles
);

    typedef struct packed {
        logic [5:0]            op_code;
        logic [5:0]            funct;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [4:0]            shamt;
        logic [1:0]            inst_type;
        logic [W-1:0]          imm;
        logic [REG_ADDR_W-1:0] reg_write_addr;
        logic [W-1:0]          pc;
        logic                  is_load;
        logic                  reads_rs;
        logic                  reads_rt;
    } dec_t;

    wire dec_t in_dec;
    wire dec_t sk_dec;
    dec_t      src_dec, out_q;

    logic                  out_v, skid_v, hold;
    logic [REG_ADDR_W-1:0] lu_rt, lu_rt_next;
    logic [W-1:0]          skid_inst, skid_pc;
    logic                  take_in, xfer_out, load_out, to_skid;
    logic                  out_v_next, skid_v_next, hold_next, dep;
    logic                  unused_out_reads;

    inst_field_decode #(.W(W), .REG_ADDR_W(REG_ADDR_W)) u_dec_in (
        .inst(inst), .pc(pc),
        .op_code(in_dec.op_code), .funct(in_dec.funct), .rs(in_dec.rs), .rt(in_dec.rt),
        .rd(in_dec.rd), .shamt(in_dec.shamt), .inst_type(in_dec.inst_type), .imm(in_dec.imm),
        .reg_write_addr(in_dec.reg_write_addr), .is_load(in_dec.is_load),
        .reads_rs(in_dec.reads_rs), .reads_rt(in_dec.reads_rt)
    );
    assign in_dec.pc = pc;

    inst_field_decode #(.W(W), .REG_ADDR_W(REG_ADDR_W)) u_dec_skid (
        .inst(skid_inst), .pc(skid_pc),
        .op_code(sk_dec.op_code), .funct(sk_dec.funct), .rs(sk_dec.rs), .rt(sk_dec.rt),
        .rd(sk_dec.rd), .shamt(sk_dec.shamt), .inst_type(sk_dec.inst_type), .imm(sk_dec.imm),
        .reg_write_addr(sk_dec.reg_write_addr), .is_load(sk_dec.is_load),
        .reads_rs(sk_dec.reads_rs), .reads_rt(sk_dec.reads_rt)
    );
    assign sk_dec.pc = skid_pc;

    always_comb begin
        take_in     = in_valid && in_ready;
        xfer_out    = out_valid && out_ready;
        load_out    = skid_v ? xfer_out : (take_in && (!out_v || xfer_out));
        to_skid     = take_in && out_v && !xfer_out;
        skid_v_next = skid_v ? !xfer_out : to_skid;
        out_v_next  = load_out || (out_v && !xfer_out);
        src_dec     = skid_v ? sk_dec : in_dec;
        // The entry entering out is compared against the load leaving at this same edge.
        lu_rt_next  = lu_rt;
        if (xfer_out)
            lu_rt_next = (out_q.is_load && out_q.rt != '0) ? out_q.rt : '0;
        dep         = (LU_DETECT != 0) && (lu_rt_next != '0) &&
                      ((src_dec.reads_rs && src_dec.rs == lu_rt_next) ||
                       (src_dec.reads_rt && src_dec.rt == lu_rt_next));
        hold_next   = load_out && dep;
    end

    // NOTE: state updates use non-blocking assignments; the payload registers are reset too
    // because out_q drives visible outputs that must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v      <= 1'b0;
            skid_v     <= 1'b0;
            hold       <= 1'b0;
            lu_rt      <= '0;
            out_q      <= '0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            lu_bubbles <= '0;
        end else if (flush) begin
            out_v     <= 1'b0;
            skid_v    <= 1'b0;
            hold      <= 1'b0;
            lu_rt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (load_out)
                out_q <= src_dec;
            if (to_skid) begin
                skid_inst <= inst;
                skid_pc   <= pc;
            end
            if (hold && lu_bubbles != '1)
                lu_bubbles <= lu_bubbles + CNT_W'(1);
            out_v     <= out_v_next;
            skid_v    <= skid_v_next;
            hold      <= hold_next;
            lu_rt     <= lu_rt_next;
            in_ready  <= !skid_v_next;
            out_valid <= out_v_next && !hold_next;
        end
    end

    assign op_code          = out_q.op_code;
    assign funct            = out_q.funct;
    assign rs               = out_q.rs;
    assign rt               = out_q.rt;
    assign rd               = out_q.rd;
    assign shamt            = out_q.shamt;
    assign inst_type        = out_q.inst_type;
    assign imm              = out_q.imm;
    assign reg_write_addr   = out_q.reg_write_addr;
    assign pc_out           = out_q.pc;
    assign unused_out_reads = out_q.reads_rs ^ out_q.reads_rt;

endmodule

// File: tb/tb_id_queue_decoder.sv
// Directed bench for id_queue_decoder: a queue-level reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_id_queue_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = '0, pc = '0;

    logic        in_ready, out_valid;
    logic [5:0]  op_code, funct;
    logic [4:0]  rs, rt, rd, shamt, reg_write_addr;
    logic [1:0]  inst_type;
    logic [31:0] imm, pc_out;
    logic [15:0] lu_bubbles;

    logic        c_in_ready, c_out_valid;
    logic [5:0]  c_op_code, c_funct;
    logic [4:0]  c_rs, c_rt, c_rd, c_shamt, c_reg_write_addr;
    logic [1:0]  c_inst_type;
    logic [31:0] c_imm, c_pc_out;
    logic [3:0]  c_lu_bubbles;

    logic        n_in_ready, n_out_valid;
    logic [5:0]  n_op_code, n_funct;
    logic [4:0]  n_rs, n_rt, n_rd, n_shamt, n_reg_write_addr;
    logic [1:0]  n_inst_type;
    logic [31:0] n_imm, n_pc_out;
    logic [15:0] n_lu_bubbles;

    always #5 clk = ~clk;

    id_queue_decoder dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .op_code(op_code), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .inst_type(inst_type), .imm(imm), .reg_write_addr(reg_write_addr),
        .pc_out(pc_out), .lu_bubbles(lu_bubbles)
    );

    id_queue_decoder #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .inst(inst), .pc(pc), .out_valid(c_out_valid), .out_ready(out_ready),
        .op_code(c_op_code), .funct(c_funct), .rs(c_rs), .rt(c_rt), .rd(c_rd), .shamt(c_shamt),
        .inst_type(c_inst_type), .imm(c_imm), .reg_write_addr(c_reg_write_addr),
        .pc_out(c_pc_out), .lu_bubbles(c_lu_bubbles)
    );

    id_queue_decoder #(.LU_DETECT(0)) dut_nolu (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
        .inst(inst), .pc(pc), .out_valid(n_out_valid), .out_ready(out_ready),
        .op_code(n_op_code), .funct(n_funct), .rs(n_rs), .rt(n_rt), .rd(n_rd), .shamt(n_shamt),
        .inst_type(n_inst_type), .imm(n_imm), .reg_write_addr(n_reg_write_addr),
        .pc_out(n_pc_out), .lu_bubbles(n_lu_bubbles)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, wa;
        logic [1:0]  ty;
        logic [31:0] imm;
        bit          ld, rrs, rrt;
    } exp_t;

    // Reference decode written straight from the opcode table.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] p);
        exp_t        e;
        logic [31:0] p4;
        p4    = p + 32'd4;
        e.op  = i[31:26]; e.fn = i[5:0]; e.rs = i[25:21]; e.rt = i[20:16];
        e.rd  = i[15:11]; e.sh = i[10:6];
        e.ty  = 2'd1; e.imm = '0; e.wa = '0; e.ld = 0; e.rrs = 1; e.rrt = 0;
        case (e.op)
            6'h00: begin
                e.ty = 2'd0; e.rrt = 1;
                e.wa = (e.fn == 6'h08) ? 5'd0 : e.rd;
                if (e.fn == 6'h00 || e.fn == 6'h02 || e.fn == 6'h03) e.imm = {27'd0, e.sh};
            end
            6'h02:             begin e.ty = 2'd2; e.rrs = 0; e.imm = {p4[31:28], i[25:0], 2'b00}; end
            6'h03:             begin e.ty = 2'd2; e.rrs = 0; e.imm = {p4[31:28], i[25:0], 2'b00}; e.wa = 5'd31; end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25:
                               begin e.ld = 1; e.imm = {{16{i[15]}}, i[15:0]}; e.wa = e.rt; end
            6'h28, 6'h29, 6'h2b: begin e.imm = {{16{i[15]}}, i[15:0]}; e.rrt = 1; end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin e.imm = {{16{i[15]}}, i[15:0]}; e.wa = e.rt; end
            6'h0c, 6'h0d, 6'h0e: begin e.imm = {16'd0, i[15:0]}; e.wa = e.rt; end
            6'h0f:             begin e.imm = {i[15:0], 16'd0}; e.wa = e.rt; e.rrs = 0; end
            6'h04, 6'h05:      begin e.imm = {{14{i[15]}}, i[15:0], 2'b00}; e.rrt = 1; end
            6'h01, 6'h06, 6'h07: e.imm = {{14{i[15]}}, i[15:0], 2'b00};
            default: ;
        endcase
        return e;
    endfunction

    // Queue model: q[0] is the instruction presented downstream.
    logic [63:0] q[$];
    bit          model_live = 0, m_hold = 0, exp_ov = 0, exp_ir = 1;
    logic [4:0]  m_lu = '0;
    int          m_bub = 0;

    task automatic enter_head();
        exp_t e;
        e      = ref_dec(q[0][63:32], q[0][31:0]);
        m_hold = (m_lu != 0) && ((e.rrs && e.rs == m_lu) || (e.rrt && e.rt == m_lu));
    endtask

    task automatic model_step();
        bit   pop, push;
        exp_t e;
        if (rst) begin
            q.delete(); m_hold = 0; m_lu = '0; m_bub = 0; model_live = 1;
        end else if (flush) begin
            q.delete(); m_hold = 0; m_lu = '0;
        end else begin
            pop  = exp_ov && out_ready;
            push = in_valid && exp_ir;
            if (m_hold) begin m_hold = 0; m_bub++; end
            if (pop) begin
                e    = ref_dec(q[0][63:32], q[0][31:0]);
                m_lu = (e.ld && e.rt != 0) ? e.rt : 5'd0;
                void'(q.pop_front());
                if (q.size() > 0) enter_head();
            end
            if (push) begin
                q.push_back({inst, pc});
                if (q.size() == 1) enter_head();
            end
        end
        exp_ov = (q.size() > 0) && !m_hold;
        exp_ir = (q.size() < 2);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (model_live) begin
            check("out_valid", out_valid, exp_ov);
            check("in_ready", in_ready, exp_ir);
            check("lu_bubbles", lu_bubbles, (m_bub > 65535) ? 65535 : m_bub);
            check("c4_out_valid", c_out_valid, exp_ov);
            check("c4_lu_bubbles", c_lu_bubbles, (m_bub > 15) ? 15 : m_bub);
            if (exp_ov) begin
                e = ref_dec(q[0][63:32], q[0][31:0]);
                check("op_code", op_code, e.op);
                check("funct", funct, e.fn);
                check("rs", rs, e.rs);
                check("rt", rt, e.rt);
                check("rd", rd, e.rd);
                check("shamt", shamt, e.sh);
                check("inst_type", inst_type, e.ty);
                check("imm", imm, e.imm);
                check("reg_write_addr", reg_write_addr, e.wa);
                check("pc_out", pc_out, q[0][31:0]);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic r, input logic f);
        in_valid = v; inst = i; pc = p; out_ready = r; flush = f;
        @(negedge clk);
    endtask

    task automatic send_imm(input logic [31:0] i, input logic [31:0] p,
                            input logic [31:0] ei, input logic [4:0] ew);
        drive(1'b1, i, p, 1'b1, 1'b0);
        check($sformatf("lit_valid_%08h", i), out_valid, 1);
        check($sformatf("lit_imm_%08h", i), imm, ei);
        check($sformatf("lit_wa_%08h", i), reg_write_addr, ew);
    endtask

    localparam logic [31:0] LW_R2  = 32'h8C220004;
    localparam logic [31:0] ADD_R3 = 32'h00441820;

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm", imm, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_wa", reg_write_addr, 0);
        check("rst_op_code", op_code, 0);
        check("rst_bubbles", lu_bubbles, 0);
        rst = 1'b0;

        // Load-use pair, back to back.
        drive(1'b1, LW_R2, 32'h100, 1'b1, 1'b0);
        check("lu_lw_valid", out_valid, 1);
        check("lu_lw_imm", imm, 32'h4);
        check("lu_lw_wa", reg_write_addr, 2);
        drive(1'b1, ADD_R3, 32'h104, 1'b1, 1'b0);
        check("lu_bubble_cycle", out_valid, 0);
        check("nolu_add_valid", n_out_valid, 1);
        check("nolu_add_wa", n_reg_write_addr, 3);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("lu_add_valid", out_valid, 1);
        check("lu_add_wa", reg_write_addr, 3);
        check("lu_count", lu_bubbles, 1);
        check("nolu_count", n_lu_bubbles, 0);
        check("nolu_drained", n_out_valid, 0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Immediate and destination forms.
        send_imm(32'h2001FFFF, 32'h1000, 32'hFFFFFFFF, 5'd1);
        send_imm(32'h3401FFFF, 32'h1004, 32'h0000FFFF, 5'd1);
        send_imm(32'h1022FFFF, 32'h1008, 32'hFFFFFFFC, 5'd0);
        send_imm(32'h3C011234, 32'h100C, 32'h12340000, 5'd1);
        send_imm(32'h08100000, 32'h80000000, 32'h80400000, 5'd0);
        send_imm(32'h0C000010, 32'h00400000, 32'h00000040, 5'd31);
        send_imm(32'h00021940, 32'h1010, 32'h00000005, 5'd3);
        send_imm(32'h03E00008, 32'h1014, 32'h00000000, 5'd0);
        send_imm(32'hAC220008, 32'h1018, 32'h00000008, 5'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Output stall: third word must be refused.
        drive(1'b1, 32'h24050001, 32'h200, 1'b0, 1'b0);
        check("stall_first_ready", in_ready, 1);
        drive(1'b1, 32'h24060002, 32'h204, 1'b0, 1'b0);
        check("stall_full_ready", in_ready, 0);
        check("stall_hold_pc", pc_out, 32'h200);
        drive(1'b1, 32'h24070003, 32'h208, 1'b0, 1'b0);
        check("stall_still_full", in_ready, 0);
        check("stall_stable_pc", pc_out, 32'h200);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("release_second_pc", pc_out, 32'h204);
        check("release_ready", in_ready, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("release_drained", out_valid, 0);

        // Flush with both entries full and a word on the input.
        drive(1'b1, 32'h24080004, 32'h300, 1'b0, 1'b0);
        drive(1'b1, 32'h24090005, 32'h304, 1'b0, 1'b0);
        drive(1'b1, 32'h240A0006, 32'h308, 1'b0, 1'b1);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_stays_empty", out_valid, 0);
        drive(1'b1, 32'h240B0007, 32'h30C, 1'b1, 1'b1);
        check("flush_drop_in", out_valid, 0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Repeated hazards to saturate the narrow counter.
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, LW_R2, 32'h400, 1'b1, 1'b0);
            drive(1'b1, ADD_R3, 32'h404, 1'b1, 1'b0);
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            drive(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("sat_c4", c_lu_bubbles, 4'hF);
        check("sat_main_count", lu_bubbles, 18);

        // Reset mid-stream wins over flush and clears the counter.
        drive(1'b1, LW_R2, 32'h500, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, ADD_R3, 32'h504, 1'b1, 1'b1);
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_ready", in_ready, 1);
        check("midrst_imm", imm, 0);
        check("midrst_count", lu_bubbles, 0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
